main_ctrl: RTL and testbench
============================

MAIN_CTRL -- requirements
Module: main_ctrl

Interface
REQ-001 Parameter MUL_LAT, default 2, meaning: MU result latency in cycles; legal range 1..8.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 opcode  input  7  instr[6:0] from datapath.
REQ-005 func3  input  3  instr[14:12] from datapath.
REQ-006 func7b5  input  1  instr[30]: 0 = func7 0x00, 1 = func7 0x20.
REQ-007 func7b0  input  1  instr[25]: 1 = M-extension (func7 0x01).
REQ-008 pcwe  output  1  PC register update enable.
REQ-009 pcctl  output  1  pcmux select; 0 = pc+4.
REQ-010 regwe  output  1  register file write enable.
REQ-011 aluctl  output  4  ALU operation code.
REQ-012 mulctl  output  2  MU operation code.
REQ-013 ifuresctl  output  1  writeback select; 0 = ALU, 1 = MU.
REQ-014 retire  output  1  one-cycle pulse per completed instruction.
REQ-015 illegal  output  1  sticky illegal-instruction flag.

Function
REQ-016 FSM states: FETCH, DECODE, MWAIT, WB, TRAP.
REQ-017 FETCH: all enables low; next state DECODE unconditionally.
REQ-018 DECODE: sample opcode/func3/func7b5/func7b0 (the only state in which they are sampled); register aluctl, mulctl, ifuresctl.
REQ-019 DECODE transitions: legal ALU op -> WB; legal MUL op -> MWAIT with counter loaded to MUL_LAT; anything else -> TRAP.
REQ-020 Legal only if opcode = 0110011 (R-type); other func7 bits are not checked.
REQ-021 func7b5=0, func7b0=0: func3 000 ADD(0), 001 SLL(2), 010 SLT(3), 011 SLTU(4), 100 XOR(5), 101 SRL(6), 110 OR(8), 111 AND(9).
REQ-022 func7b5=1, func7b0=0: func3 000 SUB(1), 101 SRA(7); all other func3 illegal.
REQ-023 func7b0=1, func7b5=0: func3 000 MUL(0), 001 MULH(1), 010 MULHSU(2), 011 MULHU(3); 100-111 (divide) illegal.
REQ-024 func7b5=1 with func7b0=1 is illegal.
REQ-025 MWAIT: counter decrements each cycle; exit to WB on the cycle the counter equals 1, so MWAIT lasts exactly MUL_LAT cycles.
REQ-026 aluctl, mulctl and ifuresctl hold their DECODE values unchanged through MWAIT and WB.
REQ-027 WB: regwe=1, pcwe=1, retire=1 for exactly one cycle; next state FETCH.
REQ-028 pcctl is constant 0 in all states.
REQ-029 Latency: ALU instruction = 3 cycles (FETCH, DECODE, WB); MUL instruction = 3+MUL_LAT cycles.
REQ-030 TRAP: illegal=1; pcwe, regwe and retire stay 0; the FSM remains in TRAP until reset.
REQ-031 regwe and pcwe are never asserted outside WB.

Reset
REQ-032 On rst: state=FETCH, counter=0, pcwe=regwe=retire=illegal=0, aluctl=0, mulctl=0, ifuresctl=0, pcctl=0.
REQ-033 Reset asserted in any state, including MWAIT or WB, aborts the instruction immediately with no write and no retire; operation resumes in FETCH on the first edge after deassertion.
REQ-034 Reset is the only exit from TRAP and clears illegal.

Structure
REQ-035 Package ctrl_pkg holds the R-type opcode constant, the 4-bit ALU op encodings, the 2-bit MUL op encodings and the FSM state enumeration; the datapath ALU/MU share these encodings.
REQ-036 Combinational sub-module r_decode maps (opcode, func3, func7b5, func7b0) to {legal, is_mul, aluctl, mulctl}; main_ctrl holds the FSM, the counter and the output registers.

Verification
REQ-037 ADD (opcode 0110011, f3 000, b5 0, b0 0) after reset -> regwe=1 and retire=1 in cycle 3 with aluctl=0, ifuresctl=0; pcwe pulses once.
REQ-038 SRA (f3 101, b5 1), then SUB (f3 000, b5 1) back-to-back -> aluctl=7 then aluctl=1; retire pulses 3 cycles apart.
REQ-039 MULHU (f3 011, b0 1), MUL_LAT=2 -> mulctl=3 and ifuresctl=1 held stable over 2 MWAIT cycles; regwe=1 in cycle 5; repeat with MUL_LAT=1 (cycle 4) and MUL_LAT=8 (cycle 11).
REQ-040 Illegal inputs (opcode 0010011; DIV f3 100 b0 1; b5=1 with b0=1; b5=1 with f3 001) -> illegal=1 from the cycle after DECODE; regwe and pcwe never assert; the flag holds until rst.
REQ-041 rst pulsed during the first MWAIT cycle of a MUL -> no regwe or retire; after release, the next instruction retires with the standard latency.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the R-type controller and the datapath ALU/MU.
package ctrl_pkg;

   localparam logic [6:0] OP_RTYPE = 7'b0110011;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } alu_op_e;

   typedef enum logic [1:0] {
      MU_MUL    = 2'd0,
      MU_MULH   = 2'd1,
      MU_MULHSU = 2'd2,
      MU_MULHU  = 2'd3
   } mul_op_e;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      MWAIT  = 3'd2,
      WB     = 3'd3,
      TRAP   = 3'd4
   } state_e;

   typedef struct packed {
      logic    legal;
      logic    is_mul;
      alu_op_e aluctl;
      mul_op_e mulctl;
   } decode_t;

endpackage

// File: rtl/r_decode.sv
// Combinational R-type / M-extension decoder.
module r_decode
   import ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] func3,
   input  logic       func7b5,
   input  logic       func7b0,
   output decode_t    dec_c
);

   always_comb begin
      dec_c = '0;
      if (opcode == OP_RTYPE) begin
         case ({func7b5, func7b0})
            2'b00: begin
               dec_c.legal = 1'b1;
               case (func3)
                  3'b000:  dec_c.aluctl = ALU_ADD;
                  3'b001:  dec_c.aluctl = ALU_SLL;
                  3'b010:  dec_c.aluctl = ALU_SLT;
                  3'b011:  dec_c.aluctl = ALU_SLTU;
                  3'b100:  dec_c.aluctl = ALU_XOR;
                  3'b101:  dec_c.aluctl = ALU_SRL;
                  3'b110:  dec_c.aluctl = ALU_OR;
                  default: dec_c.aluctl = ALU_AND;
               endcase
            end
            2'b10: begin
               if (func3 == 3'b000) begin
                  dec_c.legal  = 1'b1;
                  dec_c.aluctl = ALU_SUB;
               end else if (func3 == 3'b101) begin
                  dec_c.legal  = 1'b1;
                  dec_c.aluctl = ALU_SRA;
               end
            end
            2'b01: begin
               // Multiply ops only; func3[2] set (divide) decodes as illegal.
               if (!func3[2]) begin
                  dec_c.legal  = 1'b1;
                  dec_c.is_mul = 1'b1;
                  case (func3[1:0])
                     2'b00:   dec_c.mulctl = MU_MUL;
                     2'b01:   dec_c.mulctl = MU_MULH;
                     2'b10:   dec_c.mulctl = MU_MULHSU;
                     default: dec_c.mulctl = MU_MULHU;
                  endcase
               end
            end
            default: dec_c = '0;
         endcase
      end
   end

endmodule

// File: rtl/main_ctrl.sv
// Multi-cycle R-type control FSM: fetch, decode, optional multiply wait, writeback, trap.
module main_ctrl
   import ctrl_pkg::*;
#(
   parameter int unsigned MUL_LAT = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic [2:0] func3,
   input  logic       func7b5,
   input  logic       func7b0,
   output logic       pcwe,
   output logic       pcctl,
   output logic       regwe,
   output logic [3:0] aluctl,
   output logic [1:0] mulctl,
   output logic       ifuresctl,
   output logic       retire,
   output logic       illegal
);

   localparam int unsigned CNT_W = 4;

   decode_t          dec_c;
   state_e           state;
   logic [CNT_W-1:0] cnt;

   r_decode u_r_decode (
      .opcode  (opcode),
      .func3   (func3),
      .func7b5 (func7b5),
      .func7b0 (func7b0),
      .dec_c   (dec_c)
   );

   // Only sequential PC update is supported.
   assign pcctl = 1'b0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= FETCH;
         cnt       <= '0;
         pcwe      <= 1'b0;
         regwe     <= 1'b0;
         retire    <= 1'b0;
         illegal   <= 1'b0;
         aluctl    <= '0;
         mulctl    <= '0;
         ifuresctl <= 1'b0;
      end else begin
         pcwe   <= 1'b0;
         regwe  <= 1'b0;
         retire <= 1'b0;
         case (state)
            FETCH: state <= DECODE;
            DECODE: begin
               aluctl    <= dec_c.aluctl;
               mulctl    <= dec_c.mulctl;
               ifuresctl <= dec_c.is_mul;
               if (!dec_c.legal) begin
                  state   <= TRAP;
                  illegal <= 1'b1;
               end else if (dec_c.is_mul) begin
                  state <= MWAIT;
                  cnt   <= CNT_W'(MUL_LAT);
               end else begin
                  state  <= WB;
                  pcwe   <= 1'b1;
                  regwe  <= 1'b1;
                  retire <= 1'b1;
               end
            end
            MWAIT: begin
               // Leaving on cnt==1 makes MWAIT last exactly MUL_LAT cycles.
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  state  <= WB;
                  pcwe   <= 1'b1;
                  regwe  <= 1'b1;
                  retire <= 1'b1;
               end
            end
            WB: state <= FETCH;
            TRAP: begin
               state   <= TRAP;
               illegal <= 1'b1;
            end
            default: state <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_main_ctrl.sv
// Directed bench for main_ctrl at MUL_LAT = 1, 2 and 8 sharing one stimulus.
module tb_main_ctrl;

   logic       clk;
   logic       rst;
   logic [6:0] opcode;
   logic [2:0] func3;
   logic       func7b5;
   logic       func7b0;

   logic       pcwe2, pcctl2, regwe2, ifuresctl2, retire2, illegal2;
   logic [3:0] aluctl2;
   logic [1:0] mulctl2;
   logic       pcwe1, pcctl1, regwe1, ifuresctl1, retire1, illegal1;
   logic [3:0] aluctl1;
   logic [1:0] mulctl1;
   logic       pcwe8, pcctl8, regwe8, ifuresctl8, retire8, illegal8;
   logic [3:0] aluctl8;
   logic [1:0] mulctl8;

   int checks = 0;
   int errors = 0;

   main_ctrl #(.MUL_LAT(2)) u_dut2 (
      .clk(clk), .rst(rst), .opcode(opcode), .func3(func3),
      .func7b5(func7b5), .func7b0(func7b0),
      .pcwe(pcwe2), .pcctl(pcctl2), .regwe(regwe2), .aluctl(aluctl2),
      .mulctl(mulctl2), .ifuresctl(ifuresctl2), .retire(retire2), .illegal(illegal2)
   );

   main_ctrl #(.MUL_LAT(1)) u_dut1 (
      .clk(clk), .rst(rst), .opcode(opcode), .func3(func3),
      .func7b5(func7b5), .func7b0(func7b0),
      .pcwe(pcwe1), .pcctl(pcctl1), .regwe(regwe1), .aluctl(aluctl1),
      .mulctl(mulctl1), .ifuresctl(ifuresctl1), .retire(retire1), .illegal(illegal1)
   );

   main_ctrl #(.MUL_LAT(8)) u_dut8 (
      .clk(clk), .rst(rst), .opcode(opcode), .func3(func3),
      .func7b5(func7b5), .func7b0(func7b0),
      .pcwe(pcwe8), .pcctl(pcctl8), .regwe(regwe8), .aluctl(aluctl8),
      .mulctl(mulctl8), .ifuresctl(ifuresctl8), .retire(retire8), .illegal(illegal8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_instr(input logic [6:0] op, input logic [2:0] f3,
                            input logic b5, input logic b0);
      opcode  = op;
      func3   = f3;
      func7b5 = b5;
      func7b0 = b0;
   endtask

   // Leaves the DUTs in FETCH (cycle 1) with rst just released.
   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   localparam logic [6:0] RT = 7'b0110011;

   logic [11:0] ill [4];
   int          r1, r2, r8, cyc;
   logic        ev;

   initial begin
      ill[0] = {7'b0010011, 3'b000, 1'b0, 1'b0};
      ill[1] = {RT,         3'b100, 1'b0, 1'b1};
      ill[2] = {RT,         3'b000, 1'b1, 1'b1};
      ill[3] = {RT,         3'b001, 1'b1, 1'b0};

      // Reset values with rst held high
      rst = 1'b1;
      set_instr(RT, 3'b000, 1'b0, 1'b0);
      tick();
      tick();
      chk("rst_pcwe",      32'(pcwe2),      0);
      chk("rst_regwe",     32'(regwe2),     0);
      chk("rst_retire",    32'(retire2),    0);
      chk("rst_illegal",   32'(illegal2),   0);
      chk("rst_aluctl",    32'(aluctl2),    0);
      chk("rst_mulctl",    32'(mulctl2),    0);
      chk("rst_ifuresctl", 32'(ifuresctl2), 0);
      chk("rst_pcctl",     32'(pcctl2),     0);

      // ADD: retires in cycle 3
      rst = 1'b0;
      tick();
      chk("add_c2_regwe", 32'(regwe2), 0);
      chk("add_c2_pcwe",  32'(pcwe2),  0);
      tick();
      chk("add_c3_regwe",  32'(regwe2),     1);
      chk("add_c3_retire", 32'(retire2),    1);
      chk("add_c3_pcwe",   32'(pcwe2),      1);
      chk("add_c3_aluctl", 32'(aluctl2),    0);
      chk("add_c3_ifures", 32'(ifuresctl2), 0);
      chk("add_c3_pcctl",  32'(pcctl2),     0);
      tick();
      chk("add_c4_pcwe",   32'(pcwe2),   0);
      chk("add_c4_retire", 32'(retire2), 0);

      // SRA then SUB back-to-back
      set_instr(RT, 3'b101, 1'b1, 1'b0);
      tick();
      chk("sra_dec_retire", 32'(retire2), 0);
      tick();
      chk("sra_wb_retire", 32'(retire2), 1);
      chk("sra_wb_aluctl", 32'(aluctl2),  7);
      set_instr(RT, 3'b000, 1'b1, 1'b0);
      tick();
      chk("sub_f_retire", 32'(retire2), 0);
      tick();
      chk("sub_d_retire", 32'(retire2), 0);
      tick();
      chk("sub_wb_retire", 32'(retire2), 1);
      chk("sub_wb_aluctl", 32'(aluctl2),  1);

      // MULHU on all three latencies
      set_instr(RT, 3'b011, 1'b0, 1'b1);
      do_reset();
      r1 = 0;
      r2 = 0;
      r8 = 0;
      for (int n = 1; n <= 11; n++) begin
         tick();
         cyc = n + 1;
         if (regwe1 && r1 == 0) r1 = cyc;
         if (regwe2 && r2 == 0) r2 = cyc;
         if (regwe8 && r8 == 0) r8 = cyc;
         if (cyc == 3 || cyc == 4) begin
            chk("mulhu_mwait_mulctl", 32'(mulctl2),    3);
            chk("mulhu_mwait_ifures", 32'(ifuresctl2), 1);
            chk("mulhu_mwait_regwe",  32'(regwe2),     0);
         end
         if (cyc == 5) begin
            chk("mulhu_wb_mulctl", 32'(mulctl2),    3);
            chk("mulhu_wb_ifures", 32'(ifuresctl2), 1);
            chk("mulhu_wb_retire", 32'(retire2),    1);
         end
         if (cyc == 11) chk("mulhu8_wb_mulctl", 32'(mulctl8), 3);
      end
      chk("mulhu_lat2_cycle", 32'(r2), 5);
      chk("mulhu_lat1_cycle", 32'(r1), 4);
      chk("mulhu_lat8_cycle", 32'(r8), 11);

      // Illegal encodings trap and hold until reset
      for (int i = 0; i < 4; i++) begin
         set_instr(ill[i][11:5], ill[i][4:2], ill[i][1], ill[i][0]);
         do_reset();
         tick();
         chk("ill_dec_flag", 32'(illegal2), 0);
         tick();
         chk("ill_trap_flag", 32'(illegal2), 1);
         ev = regwe2 | pcwe2 | retire2;
         repeat (6) begin
            tick();
            ev = ev | regwe2 | pcwe2 | retire2;
         end
         chk("ill_no_write", 32'(ev), 0);
         chk("ill_sticky", 32'(illegal2), 1);
      end
      rst = 1'b1;
      #2;
      chk("ill_rst_clear", 32'(illegal2), 0);

      // Reset during the first MWAIT cycle aborts the MUL
      set_instr(RT, 3'b000, 1'b0, 1'b1);
      do_reset();
      tick();
      tick();
      chk("abort_mwait_regwe", 32'(regwe2), 0);
      rst = 1'b1;
      #2;
      chk("abort_regwe",  32'(regwe2),     0);
      chk("abort_retire", 32'(retire2),    0);
      chk("abort_mulctl", 32'(mulctl2),    0);
      chk("abort_ifures", 32'(ifuresctl2), 0);
      ev = 1'b0;
      repeat (2) begin
         tick();
         ev = ev | regwe2 | retire2;
      end
      rst = 1'b0;
      set_instr(RT, 3'b000, 1'b0, 1'b0);
      tick();
      ev = ev | regwe2 | retire2;
      chk("abort_no_write", 32'(ev), 0);
      tick();
      chk("resume_regwe",  32'(regwe2),     1);
      chk("resume_retire", 32'(retire2),    1);
      chk("resume_aluctl", 32'(aluctl2),    0);
      chk("resume_ifures", 32'(ifuresctl2), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
